// File: rtl/iterative_divider.sv
// Radix-2 restoring divider for UDIV/SDIV in the Execute stage.
// It stalls F/D/E while a divide is in flight and presents the quotient for one cycle in DONE.
module iterative_divider #(
  parameter int WIDTH            = 32,
  parameter int ALUCONTROL_WIDTH = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ALUCONTROL_WIDTH-1:0] ALUControlE,
  input  logic                        ValidE,
  input  logic                        FlushE,
  input  logic [WIDTH-1:0]            SrcAE,
  input  logic [WIDTH-1:0]            SrcBE,
  output logic                        DivStallE,
  output logic                        DivDoneE,
  output logic [WIDTH-1:0]            DivResultE,
  output logic                        DivByZeroE
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [ALUCONTROL_WIDTH-1:0] UDIV_OP = ALUCONTROL_WIDTH'(6'b101110);
  localparam logic [ALUCONTROL_WIDTH-1:0] SDIV_OP = ALUCONTROL_WIDTH'(6'b101111);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] quot;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] divisor;
  logic             negQ;
  logic             dbz;

  logic             isUdiv, isSdiv, start;
  logic [WIDTH-1:0] magA, magB, qNext;
  logic [WIDTH:0]   shifted, trial;
  logic             qBit;

  // NOTE: combinational logic uses blocking '=' with every output defaulted first so no
  // latch can be inferred; the sequential block below uses only non-blocking '<='.
  always_comb begin
    isUdiv  = (ALUControlE == UDIV_OP);
    isSdiv  = (ALUControlE == SDIV_OP);
    start   = ~reset & ValidE & ~FlushE & (state == IDLE) & (isUdiv | isSdiv);
    magA    = (isSdiv && SrcAE[WIDTH-1]) ? -SrcAE : SrcAE;
    magB    = (isSdiv && SrcBE[WIDTH-1]) ? -SrcBE : SrcBE;
    shifted = {rem[WIDTH-1:0], quot[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    // rem[WIDTH] is always clear between steps, so folding it in never changes the outcome.
    qBit    = ~(trial[WIDTH] | rem[WIDTH]);
    qNext   = {quot[WIDTH-2:0], qBit};
  end

  assign DivStallE = start | (state == CALC);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= '0;
      quot       <= '0;
      rem        <= '0;
      divisor    <= '0;
      negQ       <= 1'b0;
      dbz        <= 1'b0;
      DivDoneE   <= 1'b0;
      DivResultE <= '0;
      DivByZeroE <= 1'b0;
    end else begin
      DivDoneE   <= 1'b0;
      DivByZeroE <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (SrcBE == '0) begin
              dbz        <= 1'b1;
              quot       <= '0;
              state      <= DONE;
              DivDoneE   <= 1'b1;
              DivByZeroE <= 1'b1;
              DivResultE <= '0;
            end else begin
              quot    <= magA;
              divisor <= magB;
              rem     <= '0;
              count   <= CNT_W'(WIDTH);
              negQ    <= isSdiv & (SrcAE[WIDTH-1] ^ SrcBE[WIDTH-1]);
              state   <= CALC;
            end
          end
        end
        CALC: begin
          if (FlushE) begin
            state <= IDLE;
          end else begin
            rem   <= qBit ? trial : shifted;
            quot  <= qNext;
            count <= count - 1'b1;
            if (count == CNT_W'(1)) begin
              state      <= DONE;
              DivDoneE   <= 1'b1;
              DivResultE <= negQ ? -qNext : qNext;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          dbz   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iterative_divider.sv
// Directed bench for iterative_divider: signed/unsigned quotients, divide-by-zero,
// flush abort, back-to-back issue and mid-operation reset, checked against hand values.
module tb_iterative_divider;

  localparam logic [5:0] UDIV = 6'b101110;
  localparam logic [5:0] SDIV = 6'b101111;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  ALUControlE;
  logic        ValidE;
  logic        FlushE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        DivStallE;
  logic        DivDoneE;
  logic [31:0] DivResultE;
  logic        DivByZeroE;

  int compared   = 0;
  int mismatched = 0;

  iterative_divider #(.WIDTH(32), .ALUCONTROL_WIDTH(6)) dut (
    .clk        (clk),
    .reset      (reset),
    .ALUControlE(ALUControlE),
    .ValidE     (ValidE),
    .FlushE     (FlushE),
    .SrcAE      (SrcAE),
    .SrcBE      (SrcBE),
    .DivStallE  (DivStallE),
    .DivDoneE   (DivDoneE),
    .DivResultE (DivResultE),
    .DivByZeroE (DivByZeroE)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a divide at the current cycle (T0) and follow it to its DONE cycle (T33).
  // Returns positioned in T33 with ValidE dropped so the op leaves E on the next edge.
  task automatic runDiv(input string tag, input logic [5:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] expQ);
    ALUControlE = op;
    SrcAE       = a;
    SrcBE       = b;
    ValidE      = 1'b1;
    FlushE      = 1'b0;
    #1;
    check({tag, " stall T0"}, 32'(DivStallE), 32'd1);
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 1 || k == 32) begin
        check({tag, " stall CALC"}, 32'(DivStallE), 32'd1);
        check({tag, " done CALC"}, 32'(DivDoneE), 32'd0);
      end
    end
    tick();
    check({tag, " stall T33"}, 32'(DivStallE), 32'd0);
    check({tag, " done T33"}, 32'(DivDoneE), 32'd1);
    check({tag, " result"}, DivResultE, expQ);
    check({tag, " dbz"}, 32'(DivByZeroE), 32'd0);
    ValidE = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    ALUControlE = '0;
    ValidE      = 1'b0;
    FlushE      = 1'b0;
    SrcAE       = '0;
    SrcBE       = '0;
    tick();
    tick();
    check("reset stall", 32'(DivStallE), 32'd0);
    check("reset done", 32'(DivDoneE), 32'd0);
    check("reset result", DivResultE, 32'd0);
    check("reset dbz", 32'(DivByZeroE), 32'd0);
    reset = 1'b0;
    tick();

    // Non-divide op, invalid divide and flushed divide must all be ignored.
    ALUControlE = 6'b000100; SrcAE = 32'd100; SrcBE = 32'd7; ValidE = 1'b1;
    #1 check("nondiv stall", 32'(DivStallE), 32'd0);
    ALUControlE = UDIV; ValidE = 1'b0;
    #1 check("invalid stall", 32'(DivStallE), 32'd0);
    ValidE = 1'b1; FlushE = 1'b1;
    #1 check("flush idle stall", 32'(DivStallE), 32'd0);
    tick();
    ValidE = 1'b0; FlushE = 1'b0;
    #1 check("ignored stays idle", 32'(DivStallE), 32'd0);
    check("ignored no done", 32'(DivDoneE), 32'd0);
    tick();

    runDiv("udiv 100/7", UDIV, 32'd100, 32'd7, 32'd14);
    tick();
    runDiv("sdiv -100/7", SDIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2);
    tick();
    runDiv("sdiv 100/-7", SDIV, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2);
    tick();
    runDiv("sdiv -100/-7", SDIV, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14);
    tick();
    runDiv("udiv big/7", UDIV, 32'hFFFFFF9C, 32'd7, 32'h24924916);
    tick();
    runDiv("sdiv minint/-1", SDIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
    tick();
    runDiv("udiv max/1", UDIV, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF);
    tick();
    runDiv("udiv 5/9", UDIV, 32'd5, 32'd9, 32'd0);
    tick();

    // Divide by zero: stall only in T0, DONE in T1, idle in T2.
    ALUControlE = UDIV; SrcAE = 32'd1234; SrcBE = 32'd0; ValidE = 1'b1;
    #1 check("dbz stall T0", 32'(DivStallE), 32'd1);
    tick();
    check("dbz stall T1", 32'(DivStallE), 32'd0);
    check("dbz done T1", 32'(DivDoneE), 32'd1);
    check("dbz flag T1", 32'(DivByZeroE), 32'd1);
    check("dbz result T1", DivResultE, 32'd0);
    ValidE = 1'b0;
    tick();
    check("dbz done T2", 32'(DivDoneE), 32'd0);
    check("dbz flag T2", 32'(DivByZeroE), 32'd0);
    check("dbz stall T2", 32'(DivStallE), 32'd0);
    tick();

    // Flush at T10 aborts the SDIV; a new UDIV is accepted right away.
    ALUControlE = SDIV; SrcAE = 32'hFFFFFF9C; SrcBE = 32'd7; ValidE = 1'b1;
    #1 check("flush op stall T0", 32'(DivStallE), 32'd1);
    for (int k = 1; k <= 10; k++) tick();
    check("flush op stall T10", 32'(DivStallE), 32'd1);
    FlushE = 1'b1; ValidE = 1'b0;
    tick();
    FlushE = 1'b0;
    #1 check("flush stall T11", 32'(DivStallE), 32'd0);
    check("flush done T11", 32'(DivDoneE), 32'd0);
    runDiv("after flush 9/3", UDIV, 32'd9, 32'd3, 32'd3);
    tick();

    // Back-to-back: second op enters at T34 and completes at T67.
    runDiv("b2b 50/5", UDIV, 32'd50, 32'd5, 32'd10);
    tick();
    runDiv("b2b 81/9", UDIV, 32'd81, 32'd9, 32'd9);
    tick();

    // Reset at T15 with the op still valid: everything back to reset values at T16.
    ALUControlE = UDIV; SrcAE = 32'd1000; SrcBE = 32'd3; ValidE = 1'b1;
    #1 check("rst op stall T0", 32'(DivStallE), 32'd1);
    for (int k = 1; k <= 15; k++) tick();
    reset = 1'b1;
    tick();
    check("midrst stall", 32'(DivStallE), 32'd0);
    check("midrst done", 32'(DivDoneE), 32'd0);
    check("midrst result", DivResultE, 32'd0);
    check("midrst dbz", 32'(DivByZeroE), 32'd0);
    reset = 1'b0; ValidE = 1'b0;
    tick();
    check("post rst idle", 32'(DivStallE), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/iterative_divider.md
# iterative_divider

Multi-cycle radix-2 restoring divider in the Execute stage. It consumes the decoded `ALUControlE` and the Execute operands, and executes UDIV (6'b101110) and SDIV (6'b101111), which the single-cycle ALU does not implement. While a division is in flight, it holds the F/D/E stages through a stall request to the hazard unit. Its quotient is returned to the Execute result mux in the cycle the stall drops.

## Interface
- `WIDTH`, 32, operand/quotient width
- `ALUCONTROL_WIDTH`, 6, width of ALU control code
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; one clock; sampled on rising edge of `clk`
- `ALUControlE`  in  ALUCONTROL_WIDTH  Execute-stage ALU control code
- `ValidE`  in  1  Execute instruction valid and condition passed (CondExE)
- `FlushE`  in  1  Execute flush from hazard unit
- `SrcAE`  in  WIDTH  dividend (Rn)
- `SrcBE`  in  WIDTH  divisor (Rm)
- `DivStallE`  out  1  stall request for F/D/E (combinational)
- `DivDoneE`  out  1  quotient valid this cycle (registered)
- `DivResultE`  out  WIDTH  quotient, truncated toward zero
- `DivByZeroE`  out  1  with DivDoneE: divisor was zero

## Operation
- States: IDLE, CALC, DONE. Registers: `state`; `count` (6 b); `quot` (WIDTH); `rem` (WIDTH+1); `divisor` (WIDTH); `neg_q`; `dbz`.
- `start` = ValidE & ~FlushE & state==IDLE & (ALUControlE==6'b101110 | ALUControlE==6'b101111).
- IDLE & start, divisor != 0:
  - Load `quot`=|A| and `divisor`=|B|. Magnitudes apply only for SDIV; UDIV takes raw values.
  - Set `rem`=0, `count`=WIDTH, `neg_q` = SDIV & (A[31]^B[31]).
  - Go to CALC.
- IDLE & start, divisor == 0: set `dbz`=1, `quot`=0, go to DONE.
- CALC, one quotient bit per cycle:
  - `t` = {rem[WIDTH-1:0], quot[WIDTH-1]} − {1'b0, divisor}, computed WIDTH+1 bits wide.
  - If t[WIDTH]==0: `rem`=t and shift 1 into quot. Otherwise `rem` = the shifted value and shift 0 into quot.
  - `count` decrements. When `count`==1 on this edge, go to DONE.
- DONE:
  - DivResultE = neg_q ? −quot : quot, registered on entry.
  - DivDoneE=1. DivByZeroE=dbz.
  - Next cycle: IDLE, clear `dbz`.
  - `start` is never evaluated in DONE, so the same instruction is not restarted.
- DivStallE = start | state==CALC. It is low in DONE and IDLE.
- FlushE in CALC or DONE: next state IDLE. DivDoneE is not asserted for the aborted op.
- SDIV 0x80000000 / 0xFFFFFFFF yields 0x80000000 (wraps, no trap). UDIV/SDIV by zero yields 0 (ARM semantics).
- Non-divide ALUControlE, or ValidE=0: block stays IDLE, no stall.
- Reset: state=IDLE, count=0, quot/rem/divisor=0. DivDoneE=0, DivResultE=0, DivByZeroE=0, DivStallE=0.

## Timing
- Accept cycle T0 (IDLE, start): DivStallE=1 combinationally.
- Normal divide:
  - CALC occupies T1..T32, DivStallE=1.
  - DONE at T33: DivStallE=0, DivDoneE=1, result valid.
  - The pipeline advances on the T33→T34 edge.
  - Total Execute occupancy is 34 cycles.
- Divide-by-zero: T0 stall, T1 DONE. Occupancy is 2 cycles.
- Back-to-back divides: the second instruction enters E at T34 with state IDLE and is accepted at T34, with no bubble beyond that.
- Flush at Tk (1≤k≤32): at Tk+1 state=IDLE, DivStallE=0, DivDoneE=0.
- FlushE in the same cycle as a valid divide at IDLE: not accepted.
- Reset mid-operation: at the next edge all outputs are at reset values, regardless of FlushE/ValidE.
- DivResultE holds its last value outside DONE. Consumers must qualify it with DivDoneE.

## Test plan
- UDIV 100/7 accepted at T0 -> DivStallE high T0..T32; at T33 DivDoneE=1, DivResultE=14, DivByZeroE=0.
- SDIV 0xFFFFFF9C(−100)/7 -> T33 DivResultE=0xFFFFFFF2 (−14). Also SDIV 100/0xFFFFFFF9 -> 0xFFFFFFF2, and −100/−7 -> 14.
- SDIV 0x80000000/0xFFFFFFFF -> 0x80000000. UDIV 0xFFFFFFFF/1 -> 0xFFFFFFFF. UDIV 5/9 -> 0.
- UDIV 1234/0 -> DivStallE only at T0; T1 DivDoneE=1, DivByZeroE=1, DivResultE=0; T2 IDLE.
- SDIV started, FlushE at T10 -> T11 DivStallE=0, no DivDoneE ever. Next UDIV 9/3 accepted immediately gives 3 at +33.
- Two consecutive UDIVs (50/5 then 81/9) -> done at T33 (10) and T67 (9). Separately, reset asserted at T15 -> T16 all outputs 0, state IDLE.
